// File: rtl/spi_mnrch_pkg.sv
// Shared types and divider helpers for the SPI monarch transceiver.
// Optional feature macro used elsewhere in this slice: SPI_MNRCH_MISO_SYNC_EN.
package spi_mnrch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    XFER  = 2'd2
  } state_t;

  // Divider load value: leaves a 5-clk front porch before the counter wraps.
  function automatic int unsigned preset_cnt(input int unsigned w);
    return (32'd1 << w) - 32'd5;
  endfunction

  // Last count before SCLK rises: MISO is captured here.
  function automatic int unsigned smpl_cnt(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Last count before SCLK falls: the shift register advances here.
  function automatic int unsigned shft_cnt(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/spi_mnrch_if.sv
// Host-side command/response signals plus the SPI pins of the monarch transceiver.
interface spi_mnrch_if #(
  parameter int NBITS = 16
);
  // Handshake: wrt is a 1-clk request, accepted only while the transceiver is idle
  // (no ready back-pressure; requests while busy are dropped). done is a sticky
  // completion flag that qualifies rd_data and clears on the next accepted wrt.
  logic             wrt;
  logic [NBITS-1:0] wt_data;
  logic             done;
  logic [NBITS-1:0] rd_data;
  logic             SS_n;
  logic             SCLK;
  logic             MOSI;
  logic             MISO;

  modport master (
    input  wrt, wt_data, MISO,
    output done, rd_data, SS_n, SCLK, MOSI
  );

  modport slave (
    output wrt, wt_data, MISO,
    input  done, rd_data, SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/spi_mnrch_sclk_gen.sv
// SCLK divider: free-running counter whose MSB is SCLK, with sample/shift strobes.
module spi_sclk_gen
  import spi_mnrch_pkg::*;
#(
  parameter int SCLK_DIV_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ld,
  input  logic i_run,
  output logic o_sclk,
  output logic o_smpl,
  output logic o_shft
);

  localparam logic [SCLK_DIV_W-1:0] PRESET = SCLK_DIV_W'(preset_cnt(SCLK_DIV_W));
  localparam logic [SCLK_DIV_W-1:0] SMPL   = SCLK_DIV_W'(smpl_cnt(SCLK_DIV_W));
  localparam logic [SCLK_DIV_W-1:0] SHFT   = SCLK_DIV_W'(shft_cnt(SCLK_DIV_W));

  logic [SCLK_DIV_W-1:0] r_sclk_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_div <= PRESET;
    end else if (i_ld) begin
      r_sclk_div <= PRESET;
    end else if (i_run) begin
      r_sclk_div <= r_sclk_div + SCLK_DIV_W'(1);
    end
  end

  assign o_sclk = r_sclk_div[SCLK_DIV_W-1];
  assign o_smpl = i_run && (r_sclk_div == SMPL);
  assign o_shft = i_run && (r_sclk_div == SHFT);

endmodule

// File: rtl/spi_mnrch_xcvr.sv
// 16-bit SPI monarch transceiver: SCLK idles high, sample before rise, shift on fall, MSB first.
// Define SPI_MNRCH_MISO_SYNC_EN to pass MISO through a 2-flop synchronizer first.
module spi_mnrch_xcvr
  import spi_mnrch_pkg::*;
#(
  parameter int SCLK_DIV_W = 4,
  parameter int NBITS      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_mnrch_if.master        bus,
  output state_t             o_dbg_state
);

  localparam int CNT_W = $clog2(NBITS) + 1;

  state_t           r_state;
  state_t           w_nxt_state;
  logic             w_start;
  logic             w_finish;
  logic             w_ld;
  logic             w_run;
  logic             w_sclk;
  logic             w_smpl;
  logic             w_shft;
  logic             w_xfer_shft;
  logic             w_miso_in;
  logic [NBITS-1:0] r_shft_reg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_miso_smpl;
  logic             r_ss_n;
  logic             r_done;

  spi_sclk_gen #(.SCLK_DIV_W(SCLK_DIV_W)) u_sclk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_ld   (w_ld),
    .i_run  (w_run),
    .o_sclk (w_sclk),
    .o_smpl (w_smpl),
    .o_shft (w_shft)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt_state;
  end

  // The FRONT wrap is the suppressed first fall; only XFER wraps shift data.
  always_comb begin
    w_nxt_state = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.wrt) begin
          w_start     = 1'b1;
          w_nxt_state = FRONT;
        end
      end
      FRONT: begin
        if (w_shft) w_nxt_state = XFER;
      end
      XFER: begin
        if (w_shft && (r_bit_cnt == CNT_W'(NBITS - 1))) begin
          w_finish    = 1'b1;
          w_nxt_state = IDLE;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  assign w_ld        = (r_state == IDLE) || w_finish;
  assign w_run       = (r_state != IDLE);
  assign w_xfer_shft = (r_state == XFER) && w_shft;

`ifdef SPI_MNRCH_MISO_SYNC_EN
  logic r_miso_s1;
  logic r_miso_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= bus.MISO;
      r_miso_s2 <= r_miso_s1;
    end
  end

  assign w_miso_in = r_miso_s2;
`else
  assign w_miso_in = bus.MISO;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shft_reg  <= '0;
      r_bit_cnt   <= '0;
      r_miso_smpl <= 1'b0;
      r_ss_n      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      if (w_start) begin
        r_shft_reg <= bus.wt_data;
        r_bit_cnt  <= '0;
        r_ss_n     <= 1'b0;
        r_done     <= 1'b0;
      end else if (w_xfer_shft) begin
        r_shft_reg <= {r_shft_reg[NBITS-2:0], r_miso_smpl};
        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
        if (w_finish) begin
          r_ss_n <= 1'b1;
          r_done <= 1'b1;
        end
      end
      if ((r_state == XFER) && w_smpl) r_miso_smpl <= w_miso_in;
    end
  end

  assign bus.done     = r_done;
  assign bus.rd_data  = r_shft_reg;
  assign bus.SS_n     = r_ss_n;
  assign bus.SCLK     = w_sclk;
  assign bus.MOSI     = r_shft_reg[NBITS-1];
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_spi_mnrch_xcvr.sv
// Directed bench for spi_mnrch_xcvr: cycle-exact serf model, latency, MOSI and reset checks.
module tb_spi_mnrch_xcvr;
  import spi_mnrch_pkg::*;

`ifdef SPI_MNRCH_MISO_SYNC_EN
  localparam int LEAD = 2;
`else
  localparam int LEAD = 0;
`endif
  localparam int LATENCY = 261;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     n_chk;
  int     n_pass;

  spi_mnrch_if #(.NBITS(16)) bus ();

  spi_mnrch_xcvr #(.SCLK_DIV_W(4), .NBITS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge: pulses wrt, then plays the serf cycle by cycle.
  // Bit i is captured at the edge ending cycle 12+16*i (LEAD clks earlier with the synchronizer).
  task automatic run_frame(input logic [15:0] wdat, input logic [15:0] sdat,
                           input bit noisy, input int rewrt_at, input string tag);
    int   rises    = 0;
    int   done_at  = -1;
    int   bi       = 0;
    int   mosi_err = 0;
    int   ss_err   = 0;
    logic prev_sclk;
    logic prev_mosi;
    bus.wrt     = 1'b1;
    bus.wt_data = wdat;
    @(negedge clk);
    prev_sclk = bus.SCLK;
    prev_mosi = bus.MOSI;
    for (int k = 0; k < 300; k++) begin
      bus.wrt     = (k == rewrt_at);
      bus.wt_data = (k == rewrt_at) ? 16'hFFFF : wdat;
      if (bi < 16 && k == 12 - LEAD + 16 * bi) begin
        bus.MISO = sdat[15-bi];
        bi++;
      end else if (noisy) begin
        bus.MISO = 1'($urandom_range(0, 1));
      end
      if (bus.done === 1'b1) begin
        done_at = k;
        break;
      end
      if (bus.SS_n !== 1'b0) ss_err++;
      if (bus.SCLK === 1'b1 && prev_sclk === 1'b0) begin
        if (rises < 16 && (bus.MOSI !== wdat[15-rises] || prev_mosi !== wdat[15-rises])) mosi_err++;
        rises++;
      end
      prev_sclk = bus.SCLK;
      prev_mosi = bus.MOSI;
      @(negedge clk);
    end
    bus.wrt = 1'b0;
    chk({tag, " done latency"}, done_at, LATENCY);
    chk({tag, " rd_data"}, {16'h0, bus.rd_data}, {16'h0, sdat});
    chk({tag, " sclk rises"}, rises, 16);
    chk({tag, " mosi errors"}, mosi_err, 0);
    chk({tag, " ss_n low errors"}, ss_err, 0);
    chk({tag, " ss_n at done"}, {31'h0, bus.SS_n}, 32'd1);
    chk({tag, " sclk at done"}, {31'h0, bus.SCLK}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int ss_low;
    n_chk       = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bus.wrt     = 1'b0;
    bus.wt_data = 16'h0;
    bus.MISO    = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(20);

    // reset state
    chk("reset ss_n", {31'h0, bus.SS_n}, 32'd1);
    chk("reset sclk", {31'h0, bus.SCLK}, 32'd1);
    chk("reset done", {31'h0, bus.done}, 32'd0);
    chk("reset rd_data", {16'h0, bus.rd_data}, 32'h0);
    chk("reset mosi", {31'h0, bus.MOSI}, 32'd0);
    chk("reset state", 32'(dbg_state), 32'(IDLE));

    // single frame
    run_frame(16'hA300, 16'h00C5, 1'b0, -1, "frame_a300");
    chk("idle state after a300", 32'(dbg_state), 32'(IDLE));

    // back-to-back: second wrt on the cycle after done
    idle(4);
    run_frame(16'h0D02, 16'h3C96, 1'b0, -1, "b2b_0d02");
    run_frame(16'h1062, 16'hE117, 1'b0, -1, "b2b_1062");

    // wrt re-pulsed mid-frame is ignored
    idle(4);
    run_frame(16'h4B21, 16'h9A0F, 1'b0, 100, "rewrt_4b21");
    ss_low = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.SS_n !== 1'b1) ss_low++;
      @(negedge clk);
    end
    chk("no second frame", ss_low, 0);
    chk("rd_data held", {16'h0, bus.rd_data}, 32'h9A0F);
    chk("done held", {31'h0, bus.done}, 32'd1);

    // reset mid-frame at clk 150
    bus.wrt     = 1'b1;
    bus.wt_data = 16'hC3C3;
    @(negedge clk);
    bus.wrt = 1'b0;
    idle(150);
    chk("midframe ss_n before reset", {31'h0, bus.SS_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort ss_n", {31'h0, bus.SS_n}, 32'd1);
    chk("abort sclk", {31'h0, bus.SCLK}, 32'd1);
    chk("abort done", {31'h0, bus.done}, 32'd0);
    chk("abort rd_data", {16'h0, bus.rd_data}, 32'h0);
    chk("abort state", 32'(dbg_state), 32'(IDLE));
    idle(2);
    rst_n = 1'b1;
    idle(5);
    run_frame(16'h7E81, 16'h1248, 1'b0, -1, "post_reset");

    // MISO toggling between sample points
    idle(3);
    run_frame(16'h2BD4, 16'h5A5A, 1'b1, -1, "noisy_miso");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
